// File: rtl/sprite_pos_fetcher.sv
// sprite_pos_fetcher: fetches CHANNELS position words from a read-only memory
// port into a working bank, then publishes them all at once into the shadow
// bank seen by the renderer. Passes start on frame_start (or free-run).

// One channel: working copy filled by returning read data, shadow copy
// updated only on commit so the renderer never sees a half-written bank.
module sprite_pos_lane #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cap,
  input  logic             commit,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] pos
);
  logic [WIDTH-1:0] working;

  // capture tagged read data; publish the working word on commit
  always_ff @(posedge clk) begin
    if (reset) begin
      working <= '0;
      pos     <= '0;
    end else begin
      if (cap)    working <= din;
      if (commit) pos     <= working;
    end
  end
endmodule

module sprite_pos_fetcher #(
  parameter int WIDTH      = 16,
  parameter int CHANNELS   = 6,
  parameter int BASE_ADDR  = 6000,
  parameter int STRIDE     = 4,
  parameter int READ_LAT   = 1,
  parameter int CONTINUOUS = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_start,
  output logic [WIDTH-1:0]          mem_addr,
  input  logic [WIDTH-1:0]          mem_data,
  output logic [CHANNELS*WIDTH-1:0] positions,
  output logic                      busy,
  output logic                      updated,
  output logic                      overrun
);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(CHANNELS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_t;

  state_t                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [READ_LAT-1:0]        vld_pipe;
  logic [READ_LAT-1:0][IW-1:0] tag_pipe;
  logic                       start, issue, commit;

  assign start  = (CONTINUOUS != 0) || frame_start;
  assign issue  = (state_q == ISSUE);
  assign commit = (state_q == COMMIT);
  assign busy   = (state_q != IDLE);

  // idx is held at 0 outside ISSUE, so this reads BASE_ADDR when idle;
  // the address wraps modulo 2^WIDTH by truncation.
  assign mem_addr = WIDTH'(BASE_ADDR) + WIDTH'(idx_q) * WIDTH'(STRIDE);

  // next-state logic: issue one read per cycle, wait out the read latency,
  // then one commit cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          idx_d   = '0;
        end
      end
      ISSUE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == LAST_CNT) state_d = COMMIT;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register plus registered status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      updated <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      updated <= commit;
      overrun <= (CONTINUOUS == 0) && frame_start && busy;
    end
  end

  // tag pipeline: each issued read carries its channel index forward so the
  // returning word lands in the right slot READ_LAT cycles later
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= issue;
      tag_pipe[0] <= idx_q;
      for (int s = 1; s < READ_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic cap;
    assign cap = vld_pipe[READ_LAT-1] && (tag_pipe[READ_LAT-1] == IW'(k));
    sprite_pos_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .reset (reset),
      .cap   (cap),
      .commit(commit),
      .din   (mem_data),
      .pos   (positions[k*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_sprite_pos_fetcher.sv
// Bench for sprite_pos_fetcher: three instances (default, wrap/latency-3,
// continuous) driven by directed and random stimulus, checked against a
// pass-timeline model (pass start cycle T plus fixed offsets).
module tb_sprite_pos_fetcher;
  localparam int NI    = 3;
  localparam int MAXCH = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]       rst, fs;
  wire  [NI-1:0]       busy, upd, ovr;
  wire  [NI-1:0][15:0] addr, mdat;
  wire  [95:0]         pos0, pos2;
  wire  [31:0]         pos1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sprite_pos_fetcher u_def (
    .clk(clk), .reset(rst[0]), .frame_start(fs[0]), .mem_addr(addr[0]),
    .mem_data(mdat[0]), .positions(pos0), .busy(busy[0]), .updated(upd[0]),
    .overrun(ovr[0]));
  sprite_pos_fetcher #(.CHANNELS(2), .STRIDE(2), .BASE_ADDR(16'hFFFE), .READ_LAT(3)) u_wrap (
    .clk(clk), .reset(rst[1]), .frame_start(fs[1]), .mem_addr(addr[1]),
    .mem_data(mdat[1]), .positions(pos1), .busy(busy[1]), .updated(upd[1]),
    .overrun(ovr[1]));
  sprite_pos_fetcher #(.CONTINUOUS(1)) u_cont (
    .clk(clk), .reset(rst[2]), .frame_start(fs[2]), .mem_addr(addr[2]),
    .mem_data(mdat[2]), .positions(pos2), .busy(busy[2]), .updated(upd[2]),
    .overrun(ovr[2]));

  // instance configuration
  function automatic int p_ch(int i);   return (i == 1) ? 2 : 6; endfunction
  function automatic int p_rl(i);       return (i == 1) ? 3 : 1; endfunction
  function automatic int p_base(int i); return (i == 1) ? 'hFFFE : 6000; endfunction
  function automatic int p_str(int i);  return (i == 1) ? 2 : 4; endfunction
  function automatic bit p_cont(int i); return (i == 2); endfunction
  function automatic logic [15:0] ch_addr(int i, int k);
    return 16'((p_base(i) + k * p_str(i)) & 'hFFFF);
  endfunction

  // memories with a fixed-latency read pipeline
  logic [15:0] mem [NI][65536];
  logic [15:0] rdp [NI][3];
  always @(posedge clk)
    for (int i = 0; i < NI; i++) begin
      rdp[i][0] <= mem[i][addr[i]];
      rdp[i][1] <= rdp[i][0];
      rdp[i][2] <= rdp[i][1];
    end
  assign mdat[0] = rdp[0][0];
  assign mdat[1] = rdp[1][2];
  assign mdat[2] = rdp[2][0];

  // model: a pass accepted in cycle T is busy T+1..T+CH+RL+1, issues
  // T+1..T+CH, and publishes in T+CH+RL+2
  int          mT   [NI];
  bit          mact [NI];
  bit          movr [NI];
  logic [15:0] mwk  [NI][MAXCH];
  logic [15:0] mpos [NI][MAXCH];
  bit          chk_on = 1'b0;
  int          n_chk = 0, n_fail = 0;

  function automatic bit m_busy(int i, int c);
    return mact[i] && c >= mT[i] + 1 && c <= mT[i] + p_ch(i) + p_rl(i) + 1;
  endfunction
  function automatic bit m_issue(int i, int c);
    return mact[i] && c >= mT[i] + 1 && c <= mT[i] + p_ch(i);
  endfunction
  function automatic bit m_upd(int i, int c);
    return mact[i] && c == mT[i] + p_ch(i) + p_rl(i) + 2;
  endfunction
  function automatic logic [95:0] m_pos_vec(int i);
    logic [95:0] v = '0;
    for (int k = 0; k < p_ch(i); k++) v[k*16 +: 16] = mpos[i][k];
    return v;
  endfunction
  function automatic logic [95:0] dut_pos(int i);
    case (i)
      0:       return pos0;
      1:       return {64'b0, pos1};
      default: return pos2;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // per-cycle compare against the model, then advance the model
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (m_upd(i, cyc))
        for (int k = 0; k < MAXCH; k++) mpos[i][k] = mwk[i][k];
      if (chk_on) begin
        chk($sformatf("busy%0d", i), 96'(busy[i]), 96'(m_busy(i, cyc)));
        chk($sformatf("updated%0d", i), 96'(upd[i]), 96'(m_upd(i, cyc)));
        chk($sformatf("overrun%0d", i), 96'(ovr[i]), 96'(movr[i]));
        chk($sformatf("positions%0d", i), dut_pos(i), m_pos_vec(i));
        if (m_issue(i, cyc))
          chk($sformatf("issue_addr%0d", i), 96'(addr[i]), 96'(ch_addr(i, cyc - mT[i] - 1)));
        else if (!m_busy(i, cyc))
          chk($sformatf("idle_addr%0d", i), 96'(addr[i]), 96'(ch_addr(i, 0)));
      end
      if (rst[i]) begin
        mact[i] = 1'b0;
        movr[i] = 1'b0;
        for (int k = 0; k < MAXCH; k++) begin
          mpos[i][k] = '0;
          mwk[i][k]  = '0;
        end
      end else begin
        movr[i] = fs[i] && m_busy(i, cyc) && !p_cont(i);
        if (!m_busy(i, cyc) && (fs[i] || p_cont(i))) begin
          mT[i]   = cyc;
          mact[i] = 1'b1;
          for (int k = 0; k < p_ch(i); k++) mwk[i][k] = mem[i][ch_addr(i, k)];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  int t0, tu;
  bit seen;

  initial begin
    rst = '1;
    fs  = '1;
    for (int k = 0; k < 6; k++) begin
      mem[0][ch_addr(0, k)] = 16'h0100 + 16'(k);
      mem[2][ch_addr(2, k)] = 16'($urandom) | 16'h0001;
    end
    mem[1][16'hFFFE] = 16'h1234;
    mem[1][16'h0000] = 16'h5678;

    // reset held 3 cycles with frame_start high
    step();
    chk_on = 1'b1;
    step();
    step();
    chk("rst_addr0", 96'(addr[0]), 96'd6000);
    chk("rst_pos0", pos0, 96'h0);
    chk("rst_flags0", 96'({busy[0], upd[0], ovr[0]}), 96'h0);
    rst = '0;
    fs  = '0;
    repeat (5) step();
    chk("idle_after_rst_addr0", 96'(addr[0]), 96'd6000);
    chk("idle_after_rst_busy0", 96'(busy[0]), 96'h0);

    // first pass on default and wrap instances
    t0 = cyc;
    fs[0] = 1'b1;
    fs[1] = 1'b1;
    for (int d = 0; d <= 10; d++) begin
      @(negedge clk);
      if (d >= 1 && d <= 6)
        chk($sformatf("p1_addr_ch%0d", d - 1), 96'(addr[0]), 96'(6000 + 4 * (d - 1)));
      chk("p1_upd0", 96'(upd[0]), 96'(d == 9));
      if (d == 8) chk("p1_pos0_before", pos0, 96'h0);
      if (d == 9) chk("p1_pos0", pos0, 96'h0105_0104_0103_0102_0101_0100);
      if (d == 1) chk("wrap_addr_a", 96'(addr[1]), 96'hFFFE);
      if (d == 2) chk("wrap_addr_b", 96'(addr[1]), 96'h0000);
      chk("wrap_upd", 96'(upd[1]), 96'(d == 7));
      if (d == 7) chk("wrap_pos", 96'(pos1), 96'h5678_1234);
      step();
      fs[0] = 1'b0;
      fs[1] = 1'b0;
    end

    // second pass: atomic switch plus overrun on frame_start while busy
    for (int k = 0; k < 6; k++) mem[0][ch_addr(0, k)] = 16'h0200 + 16'(k);
    t0 = cyc;
    for (int d = 0; d <= 10; d++) begin
      fs[0] = (d == 0 || d == 3 || d == 8);
      @(negedge clk);
      chk("p2_ovr0", 96'(ovr[0]), 96'(d == 4 || d == 9));
      chk("p2_upd0", 96'(upd[0]), 96'(d == 9));
      chk("p2_pos0", pos0, (d >= 9) ? 96'h0205_0204_0203_0202_0201_0200
                                    : 96'h0105_0104_0103_0102_0101_0100);
      if (d >= 9) chk("p2_no_restart", 96'(busy[0]), 96'h0);
      step();
    end
    fs[0] = 1'b0;

    // continuous: updated spacing, bounded waits
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (upd[2]) begin seen = 1'b1; tu = cyc; end
    end
    chk("cont_first_upd_seen", 96'(seen), 96'h1);
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (upd[2]) begin seen = 1'b1; tu = cyc - tu; end
    end
    chk("cont_second_upd_seen", 96'(seen), 96'h1);
    if (seen) chk("cont_period", 96'(tu), 96'd9);
    step();

    // reset the continuous instance during ISSUE
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      if (m_issue(2, cyc)) seen = 1'b1;
      else step();
    end
    chk("cont_issue_reached", 96'(seen), 96'h1);
    rst[2] = 1'b1;
    step();
    rst[2] = 1'b0;
    chk("cont_rst_pos", pos2, 96'h0);
    chk("cont_rst_busy", 96'(busy[2]), 96'h0);
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (upd[2]) seen = 1'b1;
    end
    chk("cont_resume_upd", 96'(seen), 96'h1);
    step();

    // random phase: random starts, resets and memory rewrites between passes
    repeat (3000) begin
      for (int i = 0; i < NI; i++) begin
        fs[i]  = ($urandom_range(0, 7) == 0);
        rst[i] = ($urandom_range(0, 149) == 0);
        if (!m_busy(i, cyc) && $urandom_range(0, 3) == 0)
          for (int k = 0; k < p_ch(i); k++) mem[i][ch_addr(i, k)] = 16'($urandom);
      end
      step();
    end
    rst = '0;
    fs  = '0;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sprite_pos_fetcher.md
# sprite_pos_fetcher

Parametrised fetch engine that reads a block of CHANNELS position words (player/monster X/Y, etc.) from the read-only port of the dual-port memory. It collects them in a working bank and commits them atomically to a shadow bank that the VGA renderer reads. It generalises the fixed six-address counter/mux scheme into configurable base, stride, channel count and memory read latency. It adds frame-synchronised (tear-free) updates and overrun reporting. It sits between the memory's VGA read port and the vga block.

## Interface
- WIDTH, 16, data and address width
- CHANNELS, 6, number of words fetched per pass (≥1); channel k is read from BASE_ADDR + k*STRIDE
- BASE_ADDR, 6000, address of channel 0
- STRIDE, 4, address increment between channels
- READ_LAT, 1, cycles from mem_addr presented to mem_data valid (≥1)
- CONTINUOUS, 0, 1 = free-running passes, frame_start ignored
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- frame_start  in  1  single-cycle request to start a pass (e.g. start of vertical blank)
- mem_addr  out  WIDTH  read address to memory port A
- mem_data  in  WIDTH  read data from memory port A
- positions  out  CHANNELS*WIDTH  committed shadow bank; channel k at bits [k*WIDTH +: WIDTH]
- busy  out  1  pass in progress (ISSUE, DRAIN, COMMIT)
- updated  out  1  one-cycle pulse, high in the first cycle new positions are visible
- overrun  out  1  one-cycle pulse: frame_start arrived while busy

## Operation
- States: IDLE, ISSUE, DRAIN, COMMIT.
- IDLE: mem_addr = BASE_ADDR. On frame_start (or unconditionally when CONTINUOUS=1) -> ISSUE with idx=0.
- ISSUE: mem_addr = BASE_ADDR + idx*STRIDE, modulo 2^WIDTH (wraps silently). idx increments each cycle. After idx = CHANNELS-1 -> DRAIN.
- Tag pipeline: each ISSUE cycle pushes {valid=1, idx} into a READ_LAT-deep shift register. When an entry emerges, working[tag] <= mem_data. Non-ISSUE cycles push valid=0.
- DRAIN: exactly READ_LAT cycles (counter), then -> COMMIT.
- COMMIT: at the clock edge, positions <= working (all channels together) and updated <= 1. Next state IDLE.
- positions never changes except at the COMMIT edge or on reset. The renderer never sees a partially updated bank.
- frame_start while busy: ignored (no restart, pass unaffected). overrun = 1 in the following cycle.
- frame_start in IDLE (including the cycle in which updated is high) is accepted.
- CONTINUOUS=1: IDLE lasts exactly one cycle. overrun is never asserted.
- mem_addr and busy are decoded from registered state/idx only (glitch-free).

## Timing
- Reset (dominates all inputs): state IDLE, idx 0, tag pipeline empty, working and positions all 0, busy 0, updated 0, overrun 0, mem_addr = BASE_ADDR.
- Reset mid-pass aborts it. positions reads 0 the cycle after reset, and no updated pulse follows.
- frame_start sampled high in IDLE in cycle T:
  - ISSUE spans cycles T+1..T+CHANNELS; channel k's address is presented in cycle T+1+k.
  - Channel k's data is captured at the end of cycle T+1+k+READ_LAT.
  - DRAIN spans T+CHANNELS+1..T+CHANNELS+READ_LAT.
  - COMMIT is at T+CHANNELS+READ_LAT+1.
  - updated = 1 and new positions appear in cycle T+CHANNELS+READ_LAT+2.
- busy = 1 in cycles T+1 .. T+CHANNELS+READ_LAT+1.
- Continuous mode pass period = CHANNELS + READ_LAT + 2 cycles (9 with defaults).

## Test plan
- Reset: assert reset 3 cycles with frame_start=1 -> all positions 0, busy/updated/overrun 0, mem_addr=6000. Release -> still IDLE and mem_addr=6000 until the first frame_start sampled after release.
- Default pass: memory model with READ_LAT=1, mem[6000+4k]=0x0100+k. Pulse frame_start at cycle 10 -> mem_addr 6000,6004,…,6020 in cycles 11–16. updated=1 only in cycle 19. positions = {0x0105,…,0x0100}.
- Atomicity: after pass 1, rewrite memory to 0x0200+k and start pass 2 -> positions stays 0x0100+k through cycle T+8, then switches to 0x0200+k exactly when updated pulses.
- Overrun: frame_start at T, again at T+3 and at COMMIT cycle T+8 -> overrun pulses at T+4 and T+9. One updated at T+9. No second pass starts.
- Wrap and latency: CHANNELS=2, STRIDE=2, BASE_ADDR=0xFFFE, READ_LAT=3 -> addresses 0xFFFE then 0x0000. updated at T+7. Data correctly tagged despite 3-cycle latency.
- Continuous plus reset: CONTINUOUS=1, defaults -> updated every 9 cycles, frame_start ignored, overrun stays 0. Assert reset during ISSUE -> positions 0 next cycle, passes resume after release.
